// File: rtl/fifo_wr_pkg.sv
// Shared definitions for the FIFO write-side packer.
//   state_e            : FSM state encoding (IDLE / SEND_LO / SEND_HI)
//   DEFAULT_DATA_WIDTH : default FIFO word width
//   ERR_CNT_W          : width of the optional rejected-request counter
package fifo_wr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SEND_LO = 2'b01,
    SEND_HI = 2'b10
  } state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int ERR_CNT_W          = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on each clock edge where inc_i is high,
// sticks at all-ones, and clears only on the asynchronous reset.
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   inc_i : increment request
//   cnt_o : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_wr_packer.sv
// Write-domain producer feeding the async FIFO write-pointer stage. Takes one
// 1- or 2-byte request per transaction and writes it to the FIFO one byte at a
// time, low byte first, only while FULL is low.
//
// Ports:
//   CLK      : write-domain clock (rising edge)
//   RST      : asynchronous active-high reset
//   In_Data  : request payload, low byte in [DATA_WIDTH-1:0]
//   In_Wide  : 1 = two-byte request, 0 = low byte only
//   In_Valid : request strobe
//   In_Ready : request can be accepted this cycle
//   FULL     : FIFO full flag (same domain)
//   WR_DATA  : byte presented to the FIFO memory
//   Winc     : FIFO write enable, combinational from FULL
//   Busy     : transaction in progress
//   Err_Cnt  : saturating count of requests presented while busy
//              (only when FIFO_WR_PACKER_ERR_CNT_EN is defined)
//
// Optional feature macro: FIFO_WR_PACKER_ERR_CNT_EN
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | ready for a request, no write pending
// SEND_LO | presenting captured low byte, write when !FULL
// SEND_HI | presenting captured high byte, write when !FULL
module fifo_wr_packer
  import fifo_wr_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*DATA_WIDTH-1:0] In_Data,
  input  logic                    In_Wide,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic                    FULL,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    Winc,
  output logic                    Busy
`ifdef FIFO_WR_PACKER_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]    Err_Cnt
`endif
);

  state_e                  state_q, state_d;
  logic [2*DATA_WIDTH-1:0] data_q, data_d;
  logic                    wide_q, wide_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    wide_d  = wide_q;
    Winc    = 1'b0;
    WR_DATA = '0;
    case (state_q)
      IDLE: begin
        if (In_Valid) begin
          data_d  = In_Data;
          wide_d  = In_Wide;
          state_d = SEND_LO;
        end
      end
      SEND_LO: begin
        WR_DATA = data_q[DATA_WIDTH-1:0];
        if (!FULL) begin
          Winc    = 1'b1;
          state_d = wide_q ? SEND_HI : IDLE;
        end
      end
      SEND_HI: begin
        WR_DATA = data_q[2*DATA_WIDTH-1:DATA_WIDTH];
        if (!FULL) begin
          Winc    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      data_q  <= '0;
      wide_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      wide_q  <= wide_d;
    end
  end

  assign In_Ready = (state_q == IDLE);
  assign Busy     = ~In_Ready;

`ifdef FIFO_WR_PACKER_ERR_CNT_EN
  logic err_inc;

  // A request strobed while not ready is dropped; count it for debug.
  assign err_inc = In_Valid && !In_Ready;

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk_i(CLK),
    .rst_i(RST),
    .inc_i(err_inc),
    .cnt_o(Err_Cnt)
  );
`endif

endmodule

// File: tb/tb_fifo_wr_packer.sv
module tb_fifo_wr_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_wide;
  logic        in_valid;
  logic        in_ready;
  logic        full;
  logic [7:0]  wr_data;
  logic        winc;
  logic        busy;
`ifdef FIFO_WR_PACKER_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_packer #(
    .DATA_WIDTH(8)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .In_Data (in_data),
    .In_Wide (in_wide),
    .In_Valid(in_valid),
    .In_Ready(in_ready),
    .FULL    (full),
    .WR_DATA (wr_data),
    .Winc    (winc),
    .Busy    (busy)
`ifdef FIFO_WR_PACKER_ERR_CNT_EN
    ,
    .Err_Cnt (err_cnt)
`endif
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: bytes still owed to the FIFO for the current request.
  logic [7:0] mq[$];
  int         m_err = 0;

  typedef struct {
    logic        v;
    logic        w;
    logic [15:0] d;
    logic        f;
    logic        er;
    logic        ew;
    logic [7:0]  ed;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic v, logic w, logic [15:0] d, logic f,
                              logic er, logic ew, logic [7:0] ed);
    vec_t x;
    x.v = v; x.w = w; x.d = d; x.f = f; x.er = er; x.ew = ew; x.ed = ed;
    return x;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic v, input logic w, input logic [15:0] d, input logic f);
    in_valid = v;
    in_wide  = w;
    in_data  = d;
    full     = f;
    @(negedge clk);
  endtask

  task automatic check_err();
`ifdef FIFO_WR_PACKER_ERR_CNT_EN
    chk("err_cnt", {8'h0, err_cnt}, m_err[15:0]);
`endif
  endtask

  task automatic check_model(input string tag);
    logic r;
    logic [7:0] ed;
    r  = (mq.size() == 0);
    ed = r ? 8'h00 : mq[0];
    chk({tag, ".ready"}, {15'h0, in_ready}, {15'h0, r});
    chk({tag, ".winc"},  {15'h0, winc},     {15'h0, (!r && !full)});
    chk({tag, ".data"},  {8'h0, wr_data},   {8'h0, ed});
    chk({tag, ".busy"},  {15'h0, busy},     {15'h0, !r});
    check_err();
  endtask

  task automatic commit();
    logic r;
    logic wr;
    r  = (mq.size() == 0);
    wr = !r && !full;
    @(posedge clk);
    if (wr) begin
      void'(mq.pop_front());
    end else if (r && in_valid) begin
      mq.push_back(in_data[7:0]);
      if (in_wide) mq.push_back(in_data[15:8]);
    end
    if (in_valid && !r && m_err < 255) m_err++;
    #1;
  endtask

  initial begin
    // Directed table: wide, narrow (with ignored strobe), stall, full-after-low.
    tbl[0]  = mk(0, 0, 16'h0000, 0, 1, 0, 8'h00);
    tbl[1]  = mk(1, 1, 16'hBEEF, 0, 1, 0, 8'h00);
    tbl[2]  = mk(0, 0, 16'h0000, 0, 0, 1, 8'hEF);
    tbl[3]  = mk(0, 0, 16'h0000, 0, 0, 1, 8'hBE);
    tbl[4]  = mk(0, 0, 16'h0000, 0, 1, 0, 8'h00);
    tbl[5]  = mk(1, 0, 16'h1234, 0, 1, 0, 8'h00);
    tbl[6]  = mk(1, 1, 16'hFFFF, 0, 0, 1, 8'h34);
    tbl[7]  = mk(0, 0, 16'h0000, 0, 1, 0, 8'h00);
    tbl[8]  = mk(1, 1, 16'hA55A, 1, 1, 0, 8'h00);
    tbl[9]  = mk(0, 0, 16'h0000, 1, 0, 0, 8'h5A);
    tbl[10] = mk(0, 0, 16'h0000, 1, 0, 0, 8'h5A);
    tbl[11] = mk(0, 0, 16'h0000, 1, 0, 0, 8'h5A);
    tbl[12] = mk(0, 0, 16'h0000, 1, 0, 0, 8'h5A);
    tbl[13] = mk(0, 0, 16'h0000, 1, 0, 0, 8'h5A);
    tbl[14] = mk(0, 0, 16'h0000, 0, 0, 1, 8'h5A);
    tbl[15] = mk(0, 0, 16'h0000, 0, 0, 1, 8'hA5);
    tbl[16] = mk(0, 0, 16'h0000, 0, 1, 0, 8'h00);
    tbl[17] = mk(1, 1, 16'hC3D4, 0, 1, 0, 8'h00);
    tbl[18] = mk(0, 0, 16'h0000, 0, 0, 1, 8'hD4);
    tbl[19] = mk(0, 0, 16'h0000, 1, 0, 0, 8'hC3);
    tbl[20] = mk(0, 0, 16'h0000, 1, 0, 0, 8'hC3);
    tbl[21] = mk(0, 0, 16'h0000, 0, 0, 1, 8'hC3);
    tbl[22] = mk(0, 0, 16'h0000, 0, 1, 0, 8'h00);

    rst      = 1'b1;
    in_valid = 1'b0;
    in_wide  = 1'b0;
    in_data  = 16'h0;
    full     = 1'b0;
    #1;
    chk("rst.ready", {15'h0, in_ready}, 16'h1);
    chk("rst.winc",  {15'h0, winc},     16'h0);
    chk("rst.data",  {8'h0, wr_data},   16'h0);
    chk("rst.busy",  {15'h0, busy},     16'h0);
    check_err();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      apply(tbl[i].v, tbl[i].w, tbl[i].d, tbl[i].f);
      chk($sformatf("tbl%0d.ready", i), {15'h0, in_ready}, {15'h0, tbl[i].er});
      chk($sformatf("tbl%0d.winc", i),  {15'h0, winc},     {15'h0, tbl[i].ew});
      chk($sformatf("tbl%0d.data", i),  {8'h0, wr_data},   {8'h0, tbl[i].ed});
      chk($sformatf("tbl%0d.busy", i),  {15'h0, busy},     {15'h0, !tbl[i].er});
      check_err();
      commit();
    end

    // Reset while presenting the high byte.
    apply(1, 1, 16'h7E81, 0); check_model("mrst.acc"); commit();
    apply(0, 0, 16'h0000, 0); check_model("mrst.lo");  commit();
    apply(0, 0, 16'h0000, 0);
    chk("mrst.hi_winc", {15'h0, winc},   16'h1);
    chk("mrst.hi_data", {8'h0, wr_data}, 16'h007E);
    rst = 1'b1;
    #1;
    chk("mrst.ready", {15'h0, in_ready}, 16'h1);
    chk("mrst.winc",  {15'h0, winc},     16'h0);
    chk("mrst.data",  {8'h0, wr_data},   16'h0);
    chk("mrst.busy",  {15'h0, busy},     16'h0);
    mq.delete();
    m_err = 0;
    check_err();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst.ign_ready", {15'h0, in_ready}, 16'h1);
    in_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 16'h0000, 0);
      check_model("post_rst");
      commit();
    end

    // Strobe held through busy periods to saturate the rejected-request count.
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 3; j++) begin
        apply(1, 1, 16'($urandom), 0);
        check_model("sat");
        commit();
      end
    end
`ifdef FIFO_WR_PACKER_ERR_CNT_EN
    chk("err_sat", {8'h0, err_cnt}, 16'd255);
`endif

    // Randomized traffic with FIFO backpressure.
    for (int i = 0; i < 2000; i++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
            ($urandom_range(0, 9) < 3));
      check_model("rnd");
      commit();
    end

    in_valid = 1'b0;
    full     = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
